instr_mem_loader: RTL



---
 rtl/instr_mem_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory (2**ADDR_W x DATA_W) with a byte-serial program loader.
// The CPU fetches combinationally through read_addr/instr. cpu_reset holds the
// CPU in reset until a load has completed. Reads at or beyond prog_len return
// FILL_WORD, so a partial or abandoned load never exposes stale bytes.
module instr_mem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_end,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   prog_len,
  output logic [1:0]        state,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t              st;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                full;
  logic                accept;

  assign state = st;

  // prog_len tops out at exactly DEPTH, so its MSB alone flags a full memory.
  assign full       = prog_len[ADDR_W];
  assign load_ready = (st == LOAD) && !full;

  // A concurrent load_start restarts the load and discards the byte on the bus.
  assign accept = load_ready && load_valid && !load_start && !reset;

  // Loader FSM; load_start takes priority over everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      cpu_reset <= 1'b1;
      prog_len  <= '0;
      wr_ptr    <= '0;
      load_err  <= 1'b0;
    end else if (load_start) begin
      st        <= LOAD;
      cpu_reset <= 1'b1;
      prog_len  <= '0;
      wr_ptr    <= '0;
      load_err  <= 1'b0;
    end else begin
      case (st)
        LOAD: begin
          if (accept) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            prog_len <= prog_len + (ADDR_W+1)'(1);
          end
          // Overflow attempt: nothing written, flag stays until next load.
          if (load_valid && full) load_err <= 1'b1;
          // A byte accepted alongside load_end is still counted above.
          if (load_end) begin
            st        <= RUN;
            cpu_reset <= 1'b0;
          end
        end
        IDLE, RUN: begin
          // Only load_start (handled above) leaves these states.
        end
        default: begin
          st        <= IDLE;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  // Memory write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= load_data;
  end

  // Combinational fetch, gated by the loaded length in every state.
  always_comb begin
    instr = FILL_WORD;
    if ({1'b0, read_addr} < prog_len) instr = mem[read_addr];
  end

endmodule
